// File: rtl/systolic_sequencer.sv
// systolic_sequencer: clears, feeds skewed operand strobes to, and drains an N x N output-stationary MAC array.
module systolic_sequencer #(
  parameter int N = 4,
  parameter int K_MAX = 16,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int IW = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int TW = KW + $clog2(2 * N) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  output logic            pe_clear,
  output logic [N-1:0]    a_rd_en,
  output logic [N*IW-1:0] a_rd_k,
  output logic [N-1:0]    b_rd_en,
  output logic [N*IW-1:0] b_rd_k,
  output logic            busy,
  output logic            done,
  output logic            illegal
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] t, t_n, d, feed_end, drain_end;
  logic [KW-1:0] k_reg, k_n;
  logic legal, ill_n;
  logic [N-1:0] en_n;
  logic [N*IW-1:0] rk_n;
  assign legal = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign feed_end = TW'(k_reg) + TW'(N) - TW'(2);
  assign drain_end = TW'(k_reg) + TW'(2 * N) - TW'(3);
  always_comb begin
    state_n = state;
    t_n = t;
    k_n = k_reg;
    ill_n = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        if (legal) begin
          state_n = CLEAR;
          k_n = k_len;
        end else ill_n = 1'b1;
      end
      CLEAR: begin
        state_n = FEED;
        t_n = '0;
      end
      FEED: begin
        t_n = t + TW'(1);
        if (t == feed_end) state_n = (N == 1) ? DONE : DRAIN;
      end
      DRAIN: begin
        t_n = t + TW'(1);
        if (t == drain_end) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
    en_n = '0;
    rk_n = '0;
    d = '0;
    // row/col i lags the edge by i cycles, so its k index is t-i
    for (int i = 0; i < N; i++) begin
      d = t_n - TW'(i);
      if (state_n == FEED && t_n >= TW'(i) && d < TW'(k_n)) begin
        en_n[i] = 1'b1;
        rk_n[i*IW +: IW] = IW'(d);
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      t <= '0;
      k_reg <= '0;
      pe_clear <= 1'b1;
      a_rd_en <= '0;
      b_rd_en <= '0;
      a_rd_k <= '0;
      b_rd_k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      t <= t_n;
      k_reg <= k_n;
      pe_clear <= (state_n == IDLE) || (state_n == CLEAR);
      a_rd_en <= en_n;
      b_rd_en <= en_n;
      a_rd_k <= rk_n;
      b_rd_k <= rk_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      illegal <= ill_n;
    end
endmodule
